// File: rtl/arb_2m1s.sv
// arb_2m1s: merges two MemSplit32 masters (m0 instruction, m1 data) onto one
// downstream port. Round-robin grant, grant held while a request waits for ack,
// and an ID FIFO routing in-order read responses back to the issuing master.
module arb_2m1s #(
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // master 0
  input  logic        m0_req,
  output logic        m0_ack,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_resp,
  output logic [31:0] m0_rdata,
  // master 1
  input  logic        m1_req,
  output logic        m1_ack,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_resp,
  output logic [31:0] m1_rdata,
  // merged slave-side port
  output logic        s_req,
  input  logic        s_ack,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic        s_resp,
  input  logic [31:0] s_rdata,
  output logic        err_o
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = PW + 1;

  // masters packed so the grant index selects directly
  logic [1:0]       m_req, m_we;
  logic [1:0][31:0] m_addr, m_wdata;
  logic [1:0][3:0]  m_be;

  assign m_req   = {m1_req, m0_req};
  assign m_we    = {m1_we, m0_we};
  assign m_addr  = {m1_addr, m0_addr};
  assign m_wdata = {m1_wdata, m0_wdata};
  assign m_be    = {m1_be, m0_be};

  logic                  rr_last, lock_vld, lock_id, gnt;
  logic [RESP_DEPTH-1:0] id_q;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, issue, accept, push, pop, head_id;

  // grant: held master while locked, else the lone requester, else the one not served last
  always_comb begin
    gnt = ~rr_last;
    if (lock_vld)           gnt = lock_id;
    else if (m_req == 2'b01) gnt = 1'b0;
    else if (m_req == 2'b10) gnt = 1'b1;
  end

  // full uses the registered count only, so a same-cycle pop never unblocks a read
  assign full    = (count == CW'(RESP_DEPTH));
  assign issue   = rst_n_i && m_req[gnt] && !(!m_we[gnt] && full);
  assign accept  = issue && s_ack;
  assign push    = accept && !m_we[gnt];
  assign pop     = rst_n_i && s_resp && (count != '0);
  assign head_id = id_q[rd_ptr];

  assign s_req   = issue;
  assign s_we    = issue && m_we[gnt];
  assign s_addr  = issue ? m_addr[gnt]  : '0;
  assign s_be    = issue ? m_be[gnt]    : '0;
  assign s_wdata = issue ? m_wdata[gnt] : '0;
  assign m0_ack  = accept && !gnt;
  assign m1_ack  = accept && gnt;

  assign m0_resp  = pop && !head_id;
  assign m1_resp  = pop && head_id;
  assign m0_rdata = m0_resp ? s_rdata : '0;
  assign m1_rdata = m1_resp ? s_rdata : '0;

  // round-robin history and grant lock while the slave stalls
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_last  <= 1'b1;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else if (accept) begin
      rr_last  <= gnt;
      lock_vld <= 1'b0;
    end else if (issue) begin
      lock_vld <= 1'b1;
      lock_id  <= gnt;
    end
  end

  // ID FIFO: one entry per outstanding read, popped in order by responses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr] <= gnt;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky error on a response with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      err_o <= 1'b0;
    else if (s_resp && count == '0)    err_o <= 1'b1;
  end
endmodule

// File: tb/tb_arb_2m1s.sv
// Scoreboard bench for arb_2m1s: stimulus pushes expected slave-side issues and
// master-side responses; negedge monitors pop and compare.
module tb_arb_2m1s;
  logic        clk, rst_n;
  logic        m0_req, m0_ack, m0_we, m0_resp;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_ack, m1_we, m1_resp;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        s_req, s_ack, s_we, s_resp, err_o;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int n_chk = 0, n_pass = 0;

  typedef struct packed {
    logic        mid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } iss_t;
  typedef struct packed {
    logic        mid;
    logic [31:0] data;
  } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  arb_2m1s #(.RESP_DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req(m0_req), .m0_ack(m0_ack), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_ack(m1_ack), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_ack(s_ack), .s_we(s_we), .s_addr(s_addr), .s_be(s_be),
    .s_wdata(s_wdata), .s_resp(s_resp), .s_rdata(s_rdata), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [3:0] be_of(input logic m);
    return m ? 4'h3 : 4'hF;
  endfunction

  task automatic drv_m(input logic m, input logic req, input logic we, input logic [31:0] addr);
    if (!m) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = ~addr; m0_be = be_of(m);
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = ~addr; m1_be = be_of(m);
    end
  endtask

  task automatic exp_iss(input logic m, input logic we, input logic [31:0] addr);
    iss_t e;
    e.mid = m; e.we = we; e.addr = addr; e.wdata = ~addr; e.be = be_of(m);
    iss_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic m, input logic [31:0] d);
    rsp_t e;
    e.mid = m; e.data = d;
    rsp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // issue monitor: every accepted slave-side request must match the next expected one
  always @(negedge clk) begin
    if (s_req && s_ack) begin
      if (iss_q.size() == 0) begin
        n_chk++;
        $display("FAIL iss_unexpected: got addr 0x%08h with no issue expected", s_addr);
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        check("iss_addr", s_addr, e.addr);
        check("iss_we", 32'(s_we), 32'(e.we));
        check("iss_wdata", s_wdata, e.wdata);
        check("iss_be", 32'(s_be), 32'(e.be));
        check("iss_m0_ack", 32'(m0_ack), 32'(!e.mid));
        check("iss_m1_ack", 32'(m1_ack), 32'(e.mid));
      end
    end
  end

  // response monitor: routed read data must reach the expected master only
  always @(negedge clk) begin
    if (m0_resp || m1_resp) begin
      if (rsp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: got m0_resp=%0b m1_resp=%0b with none expected",
                 m0_resp, m1_resp);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_m0", 32'(m0_resp), 32'(!e.mid));
        check("rsp_m1", 32'(m1_resp), 32'(e.mid));
        check("rsp_data", e.mid ? m1_rdata : m0_rdata, e.data);
        check("rsp_other_rdata", e.mid ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = 32'h0;
    #12;
    check("rst_s_req", 32'(s_req), 32'h0);
    check("rst_m0_ack", 32'(m0_ack), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: contention, always-ack -> m0,m1,m0,m1; responses routed in order
    drv_m(1'b0, 1'b1, 1'b0, 32'h100);
    drv_m(1'b1, 1'b1, 1'b0, 32'h200);
    s_ack = 1'b1;
    for (int i = 0; i < 4; i++) exp_iss(i[0], 1'b0, i[0] ? 32'h200 : 32'h100);
    repeat (4) tick();
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    for (int i = 0; i < 4; i++) exp_rsp(i[0], 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      s_resp = 1'b1; s_rdata = 32'hA0 + 32'(i);
      tick();
    end
    s_resp = 1'b0; s_rdata = 32'h0;

    // 2: m1 stalled 3 cycles, grant held despite m0 rising; m0 served after
    drv_m(1'b1, 1'b1, 1'b0, 32'h200);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drv_m(1'b0, 1'b1, 1'b0, 32'h100);
      @(negedge clk);
      check("lock_s_req", 32'(s_req), 32'h1);
      check("lock_s_addr", s_addr, 32'h200);
      check("lock_m0_ack", 32'(m0_ack), 32'h0);
      tick();
    end
    s_ack = 1'b1;
    exp_iss(1'b1, 1'b0, 32'h200);
    tick();
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    exp_iss(1'b0, 1'b0, 32'h100);
    tick();
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    exp_rsp(1'b1, 32'hB0);
    exp_rsp(1'b0, 32'hB1);
    for (int i = 0; i < 2; i++) begin
      s_resp = 1'b1; s_rdata = 32'hB0 + 32'(i);
      tick();
    end
    s_resp = 1'b0; s_rdata = 32'h0;

    // 3: four outstanding reads fill the FIFO; 5th blocks, a write still passes
    drv_m(1'b0, 1'b1, 1'b0, 32'h300);
    s_ack = 1'b1;
    for (int i = 0; i < 4; i++) exp_iss(1'b0, 1'b0, 32'h300);
    repeat (4) tick();
    @(negedge clk);
    check("full_s_req", 32'(s_req), 32'h0);
    check("full_m0_ack", 32'(m0_ack), 32'h0);
    tick();
    drv_m(1'b1, 1'b1, 1'b1, 32'h400);
    exp_iss(1'b1, 1'b1, 32'h400);
    @(negedge clk);
    check("full_wr_m0_ack", 32'(m0_ack), 32'h0);
    tick();
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_resp = 1'b1; s_rdata = 32'hC0;
    exp_rsp(1'b0, 32'hC0);
    @(negedge clk);
    check("full_pop_same_cycle", 32'(s_req), 32'h0);
    tick();
    s_resp = 1'b0; s_rdata = 32'h0;
    exp_iss(1'b0, 1'b0, 32'h300);
    tick();
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    for (int i = 1; i < 5; i++) begin
      exp_rsp(1'b0, 32'hC0 + 32'(i));
      s_resp = 1'b1; s_rdata = 32'hC0 + 32'(i);
      tick();
    end
    s_resp = 1'b0; s_rdata = 32'h0;

    // 4: writes only, alternating from m1 (m0 served last); no responses expected
    drv_m(1'b0, 1'b1, 1'b1, 32'h500);
    drv_m(1'b1, 1'b1, 1'b1, 32'h600);
    s_ack = 1'b1;
    for (int i = 0; i < 10; i++) exp_iss(!i[0], 1'b1, i[0] ? 32'h500 : 32'h600);
    repeat (10) tick();
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;

    // 5: response with nothing outstanding -> dropped, sticky error
    s_resp = 1'b1; s_rdata = 32'hEE;
    @(negedge clk);
    check("unexp_m0_resp", 32'(m0_resp), 32'h0);
    check("unexp_m1_resp", 32'(m1_resp), 32'h0);
    check("err_before_edge", 32'(err_o), 32'h0);
    tick();
    s_resp = 1'b0; s_rdata = 32'h0;
    check("err_set", 32'(err_o), 32'h1);
    repeat (3) tick();
    check("err_sticky", 32'(err_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("err_cleared_by_rst", 32'(err_o), 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // 6: reset mid-operation with two reads outstanding
    drv_m(1'b0, 1'b1, 1'b0, 32'h700);
    s_ack = 1'b1;
    exp_iss(1'b0, 1'b0, 32'h700);
    tick();
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    drv_m(1'b1, 1'b1, 1'b0, 32'h800);
    exp_iss(1'b1, 1'b0, 32'h800);
    tick();
    rst_n = 1'b0;
    s_resp = 1'b1; s_rdata = 32'hF0;
    #1;
    check("mid_rst_s_req", 32'(s_req), 32'h0);
    check("mid_rst_s_addr", s_addr, 32'h0);
    check("mid_rst_m1_ack", 32'(m1_ack), 32'h0);
    check("mid_rst_m0_resp", 32'(m0_resp), 32'h0);
    check("mid_rst_m1_rdata", m1_rdata, 32'h0);
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = 32'h0;
    #2 rst_n = 1'b1;
    tick();
    s_resp = 1'b1; s_rdata = 32'hF1;
    @(negedge clk);
    check("post_rst_m0_resp", 32'(m0_resp), 32'h0);
    check("post_rst_m1_resp", 32'(m1_resp), 32'h0);
    tick();
    s_resp = 1'b0; s_rdata = 32'h0;
    check("post_rst_err", 32'(err_o), 32'h1);
    drv_m(1'b0, 1'b1, 1'b0, 32'h700);
    drv_m(1'b1, 1'b1, 1'b0, 32'h800);
    s_ack = 1'b1;
    exp_iss(1'b0, 1'b0, 32'h700);
    exp_iss(1'b1, 1'b0, 32'h800);
    repeat (2) tick();
    drv_m(1'b0, 1'b0, 1'b0, 32'h0);
    drv_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    exp_rsp(1'b0, 32'hD0);
    exp_rsp(1'b1, 32'hD1);
    for (int i = 0; i < 2; i++) begin
      s_resp = 1'b1; s_rdata = 32'hD0 + 32'(i);
      tick();
    end
    s_resp = 1'b0; s_rdata = 32'h0;
    repeat (2) tick();

    check("iss_q_drained", 32'(iss_q.size()), 32'h0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
